mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single 128-bit main-memory port between the instruction cache and the data cache. Exactly one line-sized transaction is in flight at a time: one request, then four write-data beats or four read-response beats. The arbiter sits between the two cache instances and the memory interface in the top-level CPU wrapper. A grant is held for the whole transaction, so a cache never sees another cache's beats.

## Interface
Parameters:
- ADDR_BITS, 28, width of the line-granular memory address (`mem_req_addr`).
- DATA_BITS, 128, memory beat width (`MEM_DATA_BITS`).
- BEATS, 4, beats per cache line; must be a power of two ≥ 2.

Ports (prefix `ic_` = instruction cache side, `dc_` = data cache side; each side has the same set of signals):
- clk  in  1  single clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low.
- {ic,dc}_req_val  in  1  transaction request.
- {ic,dc}_req_rdy  out  1  request accepted this cycle.
- {ic,dc}_req_addr  in  ADDR_BITS  line address.
- {ic,dc}_req_rw  in  1  1 = write, 0 = read.
- {ic,dc}_data_valid  in  1  write beat valid.
- {ic,dc}_data_ready  out  1  write beat accepted.
- {ic,dc}_data_bits  in  DATA_BITS  write beat.
- {ic,dc}_data_mask  in  DATA_BITS/8  byte mask.
- {ic,dc}_resp_val  out  1  read beat for this side.
- {ic,dc}_resp_data  out  DATA_BITS  read beat.
- mem_req_val/mem_req_rdy/mem_req_addr/mem_req_rw  out/in/out/out  1/1/ADDR_BITS/1  memory request channel.
- mem_req_data_valid/mem_req_data_ready/mem_req_data_bits/mem_req_data_mask  out/in/out/out  1/1/DATA_BITS/DATA_BITS/8  memory write-data channel.
- mem_resp_val/mem_resp_data  in/in  1/DATA_BITS  memory read response.
- err  out  1  sticky protocol error.

## Operation
- States: IDLE, REQ, WDATA, RDATA. Registered `owner` (IC or DC). Beat counter `cnt` is log2(BEATS) bits.
- IDLE:
  - If any `*_req_val` is high, latch the winner into `owner`, go to REQ.
  - Default priority: DC wins ties.
  - No handshake to any side in IDLE.
- REQ:
  - `mem_req_val`, `mem_req_addr` and `mem_req_rw` mux from the owner.
  - The owner's `req_rdy` = `mem_req_rdy`; the other side's `req_rdy` = 0.
  - On fire (val & rdy): rw=1 → WDATA; rw=0 → RDATA; `cnt` ← 0.
  - If the owner drops `req_val` before fire, the arbiter stays in REQ; clients must hold `req_val` until fire.
- WDATA:
  - The owner's data channel connects to `mem_req_data_*`; the other side's `data_ready` = 0.
  - Each data fire increments `cnt`. The fire with `cnt` = BEATS-1 → IDLE.
- RDATA:
  - `mem_resp_data` is broadcast to both `*_resp_data` in every state.
  - `*_resp_val` = `mem_resp_val` & (owner matches) & state==RDATA.
  - Each beat increments `cnt`; the beat with `cnt` = BEATS-1 → IDLE.
- `mem_resp_val` outside RDATA: the beat is dropped, no `resp_val` is raised, and `err` ← 1.
- `err` clears only on reset.
- `cnt` wraps modulo BEATS; with the default BEATS=4, 2'b11 → 2'b00 on the final beat.

## Timing
- Reset (asynchronous assert, synchronous-edge release):
  - state = IDLE, owner = DC, cnt = 0, err = 0.
  - Every output valid/ready = 0.
  - Address/data outputs: don't-care, driven as 0.
- Arbitration latency:
  - A request seen in IDLE at edge N raises `mem_req_val` in cycle N+1.
  - With `mem_req_rdy` = 1, the earliest `req_rdy` to the client is also N+1.
- Back-to-back: after the last beat the arbiter returns to IDLE for one cycle, so the minimum gap between transactions is 1 cycle.
- A new request arriving during a transaction waits. The losing side's pending `req_val` is served at the next IDLE.
- Final read beat and a new request in the same cycle: the new request is arbitrated in the following IDLE cycle.
- Reset mid-transaction aborts immediately. Memory-side beats after reset release are counted as errors.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin arbitration. A one-bit `last` register (reset = IC) records the previous owner.
  - On a tie the side that was not `last` wins.
- Undefined: fixed priority, DC always wins ties; no `last` register.

## Test plan
- Single read: dc_req_val=1, rw=0, addr=28'h0000040; memory returns 4 beats A0..A3 → mem_req_addr=28'h0000040; dc_resp_val high exactly 4 cycles with A0..A3; ic_resp_val stays 0; state back to IDLE.
- Single write: ic write, addr=28'h0000100, beats 0x11..0x44, mask 16'hFFFF, mem_req_data_ready toggling 1/0 → exactly 4 mem_req_data fires in order; ic_data_ready mirrors ready; then IDLE.
- Tie: both req_val asserted in the same cycle, both reads:
  - Without `MEM_ARB_RR_EN`: DC served, then IC.
  - With it, repeated ties alternate DC, IC, DC.
- Stall: mem_req_rdy=0 for 5 cycles in REQ → mem_req_val held with a stable address, owner's req_rdy = 0, no state change.
- Spurious response: mem_resp_val=1 in IDLE → no resp_val on either side, err=1 and stays 1 through later transactions.
- Reset mid-transaction: reset low during the 3rd read beat → all outputs 0 immediately; after release a fresh ic read completes normally with 4 beats.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter sharing one line-granular memory port between the I-cache and D-cache.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D-cache always wins ties.
module mem_arbiter #(
   parameter int ADDR_BITS = 28,
   parameter int DATA_BITS = 128,
   parameter int BEATS     = 4
) (
   input  logic                   clk,
   input  logic                   reset,

   input  logic                   ic_req_val,
   output logic                   ic_req_rdy,
   input  logic [ADDR_BITS-1:0]   ic_req_addr,
   input  logic                   ic_req_rw,
   input  logic                   ic_data_valid,
   output logic                   ic_data_ready,
   input  logic [DATA_BITS-1:0]   ic_data_bits,
   input  logic [DATA_BITS/8-1:0] ic_data_mask,
   output logic                   ic_resp_val,
   output logic [DATA_BITS-1:0]   ic_resp_data,

   input  logic                   dc_req_val,
   output logic                   dc_req_rdy,
   input  logic [ADDR_BITS-1:0]   dc_req_addr,
   input  logic                   dc_req_rw,
   input  logic                   dc_data_valid,
   output logic                   dc_data_ready,
   input  logic [DATA_BITS-1:0]   dc_data_bits,
   input  logic [DATA_BITS/8-1:0] dc_data_mask,
   output logic                   dc_resp_val,
   output logic [DATA_BITS-1:0]   dc_resp_data,

   output logic                   mem_req_val,
   input  logic                   mem_req_rdy,
   output logic [ADDR_BITS-1:0]   mem_req_addr,
   output logic                   mem_req_rw,
   output logic                   mem_req_data_valid,
   input  logic                   mem_req_data_ready,
   output logic [DATA_BITS-1:0]   mem_req_data_bits,
   output logic [DATA_BITS/8-1:0] mem_req_data_mask,
   input  logic                   mem_resp_val,
   input  logic [DATA_BITS-1:0]   mem_resp_data,

   output logic                   err
);

   localparam int CNT_BITS = $clog2(BEATS);
   localparam logic [CNT_BITS-1:0] LAST_BEAT = CNT_BITS'(BEATS - 1);
   localparam logic OWN_IC = 1'b0;
   localparam logic OWN_DC = 1'b1;

   typedef enum logic [1:0] {IDLE, REQ, WDATA, RDATA} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic [CNT_BITS-1:0] cnt_q, cnt_d;
   logic                err_q, err_d;

   logic                inReq, inWdata, inRdata;
   logic                ownIc, ownDc;
   logic                selReqVal, selReqRw, selDataValid;
   logic [ADDR_BITS-1:0]   selReqAddr;
   logic [DATA_BITS-1:0]   selDataBits;
   logic [DATA_BITS/8-1:0] selDataMask;
   logic                reqFire, dataFire, respBeat;
   logic                anyReq, winner;

   assign inReq   = (state_q == REQ);
   assign inWdata = (state_q == WDATA);
   assign inRdata = (state_q == RDATA);
   assign ownIc   = (owner_q == OWN_IC);
   assign ownDc   = (owner_q == OWN_DC);

   assign selReqVal    = ownDc ? dc_req_val    : ic_req_val;
   assign selReqRw     = ownDc ? dc_req_rw     : ic_req_rw;
   assign selReqAddr   = ownDc ? dc_req_addr   : ic_req_addr;
   assign selDataValid = ownDc ? dc_data_valid : ic_data_valid;
   assign selDataBits  = ownDc ? dc_data_bits  : ic_data_bits;
   assign selDataMask  = ownDc ? dc_data_mask  : ic_data_mask;

   // Channels only open in the phase that uses them; idle outputs are forced to zero.
   assign mem_req_val  = inReq & selReqVal;
   assign mem_req_rw   = inReq & selReqRw;
   assign mem_req_addr = inReq ? selReqAddr : '0;
   assign ic_req_rdy   = inReq & ownIc & mem_req_rdy;
   assign dc_req_rdy   = inReq & ownDc & mem_req_rdy;

   assign mem_req_data_valid = inWdata & selDataValid;
   assign mem_req_data_bits  = inWdata ? selDataBits : '0;
   assign mem_req_data_mask  = inWdata ? selDataMask : '0;
   assign ic_data_ready      = inWdata & ownIc & mem_req_data_ready;
   assign dc_data_ready      = inWdata & ownDc & mem_req_data_ready;

   assign ic_resp_data = mem_resp_data;
   assign dc_resp_data = mem_resp_data;
   assign ic_resp_val  = inRdata & ownIc & mem_resp_val;
   assign dc_resp_val  = inRdata & ownDc & mem_resp_val;

   assign err = err_q;

   assign reqFire  = mem_req_val & mem_req_rdy;
   assign dataFire = mem_req_data_valid & mem_req_data_ready;
   assign respBeat = inRdata & mem_resp_val;
   assign anyReq   = ic_req_val | dc_req_val;

`ifdef MEM_ARB_RR_EN
   logic last_q, last_d;

   // On a tie the side that did not own the previous transaction goes first.
   assign winner = (ic_req_val & dc_req_val) ? ~last_q : dc_req_val;
`else
   assign winner = dc_req_val;
`endif

   // Next-state logic: arbitrate in IDLE, then follow the owner through one line transfer.
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      err_d   = err_q | (mem_resp_val & ~inRdata);
`ifdef MEM_ARB_RR_EN
      last_d  = last_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (anyReq) begin
               owner_d = winner;
               state_d = REQ;
`ifdef MEM_ARB_RR_EN
               last_d  = winner;
`endif
            end
         end
         REQ: begin
            if (reqFire) begin
               state_d = selReqRw ? WDATA : RDATA;
               cnt_d   = '0;
            end
         end
         WDATA: begin
            if (dataFire) begin
               cnt_d = cnt_q + CNT_BITS'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
               end
            end
         end
         RDATA: begin
            if (respBeat) begin
               cnt_d = cnt_q + CNT_BITS'(1);
               if (cnt_q == LAST_BEAT) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset aborts any transaction in flight; the error flag is sticky until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         owner_q <= OWN_DC;
         cnt_q   <= '0;
         err_q   <= 1'b0;
`ifdef MEM_ARB_RR_EN
         last_q  <= OWN_IC;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
`ifdef MEM_ARB_RR_EN
         last_q  <= last_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: reads, writes, ties, stalls,
// spurious responses and reset in the middle of a read burst.
module tb_mem_arbiter;

   logic          clk = 1'b0;
   logic          reset = 1'b0;

   logic          ic_req_val = 1'b0, ic_req_rdy, ic_req_rw = 1'b0;
   logic [27:0]   ic_req_addr = '0;
   logic          ic_data_valid = 1'b0, ic_data_ready;
   logic [127:0]  ic_data_bits = '0;
   logic [15:0]   ic_data_mask = '0;
   logic          ic_resp_val;
   logic [127:0]  ic_resp_data;

   logic          dc_req_val = 1'b0, dc_req_rdy, dc_req_rw = 1'b0;
   logic [27:0]   dc_req_addr = '0;
   logic          dc_data_valid = 1'b0, dc_data_ready;
   logic [127:0]  dc_data_bits = '0;
   logic [15:0]   dc_data_mask = '0;
   logic          dc_resp_val;
   logic [127:0]  dc_resp_data;

   logic          mem_req_val, mem_req_rdy = 1'b0, mem_req_rw;
   logic [27:0]   mem_req_addr;
   logic          mem_req_data_valid, mem_req_data_ready = 1'b0;
   logic [127:0]  mem_req_data_bits;
   logic [15:0]   mem_req_data_mask;
   logic          mem_resp_val = 1'b0;
   logic [127:0]  mem_resp_data = '0;
   logic          err;

   int total = 0;
   int bad   = 0;

   mem_arbiter dut (
      .clk(clk), .reset(reset),
      .ic_req_val(ic_req_val), .ic_req_rdy(ic_req_rdy), .ic_req_addr(ic_req_addr),
      .ic_req_rw(ic_req_rw), .ic_data_valid(ic_data_valid), .ic_data_ready(ic_data_ready),
      .ic_data_bits(ic_data_bits), .ic_data_mask(ic_data_mask),
      .ic_resp_val(ic_resp_val), .ic_resp_data(ic_resp_data),
      .dc_req_val(dc_req_val), .dc_req_rdy(dc_req_rdy), .dc_req_addr(dc_req_addr),
      .dc_req_rw(dc_req_rw), .dc_data_valid(dc_data_valid), .dc_data_ready(dc_data_ready),
      .dc_data_bits(dc_data_bits), .dc_data_mask(dc_data_mask),
      .dc_resp_val(dc_resp_val), .dc_resp_data(dc_resp_data),
      .mem_req_val(mem_req_val), .mem_req_rdy(mem_req_rdy), .mem_req_addr(mem_req_addr),
      .mem_req_rw(mem_req_rw), .mem_req_data_valid(mem_req_data_valid),
      .mem_req_data_ready(mem_req_data_ready), .mem_req_data_bits(mem_req_data_bits),
      .mem_req_data_mask(mem_req_data_mask), .mem_resp_val(mem_resp_val),
      .mem_resp_data(mem_resp_data), .err(err)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any difference.
   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advances to the next falling edge and drives the memory side for that cycle.
   task automatic applyStimulus(input logic respVal, input logic [127:0] respData, input logic reqRdy);
      @(negedge clk);
      mem_resp_val  = respVal;
      mem_resp_data = respData;
      mem_req_rdy   = reqRdy;
   endtask

   // One complete read: IDLE cycle, REQ cycle, then four response beats.
   task automatic runRead(input logic icVal, input logic dcVal, input logic expDc,
                          input logic [27:0] expAddr, input logic [127:0] base);
      applyStimulus(1'b0, '0, 1'b1);
      ic_req_val = icVal;
      dc_req_val = dcVal;
      ic_req_rw  = 1'b0;
      dc_req_rw  = 1'b0;
      #1;
      checkOutput("idle_mem_req_val", mem_req_val, 1'b0);
      checkOutput("idle_req_rdy", {ic_req_rdy, dc_req_rdy}, 2'b00);
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("req_mem_req_val", mem_req_val, 1'b1);
      checkOutput("req_addr", mem_req_addr, expAddr);
      checkOutput("req_rw", mem_req_rw, 1'b0);
      checkOutput("req_rdy_owner", {ic_req_rdy, dc_req_rdy}, expDc ? 2'b01 : 2'b10);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, base + 128'(i), 1'b1);
         #1;
         checkOutput("resp_val_side", {ic_resp_val, dc_resp_val}, expDc ? 2'b01 : 2'b10);
         checkOutput("resp_data", expDc ? dc_resp_data : ic_resp_data, base + 128'(i));
      end
   endtask

   initial begin
      logic [127:0] wbeat [4];
      logic [2:0]   tieDc;
      int           idx;
      logic         readyExp;

      wbeat[0] = 128'h11;
      wbeat[1] = 128'h22;
      wbeat[2] = 128'h33;
      wbeat[3] = 128'h44;
`ifdef MEM_ARB_RR_EN
      tieDc = 3'b101;
`else
      tieDc = 3'b111;
`endif

      repeat (2) @(negedge clk);
      #1;
      checkOutput("rst_mem_req_val", mem_req_val, 1'b0);
      checkOutput("rst_req_rdy", {ic_req_rdy, dc_req_rdy}, 2'b00);
      checkOutput("rst_data_valid", mem_req_data_valid, 1'b0);
      checkOutput("rst_data_ready", {ic_data_ready, dc_data_ready}, 2'b00);
      checkOutput("rst_resp_val", {ic_resp_val, dc_resp_val}, 2'b00);
      checkOutput("rst_addr", mem_req_addr, 28'h0);
      checkOutput("rst_err", err, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      $display("[TB] single read from data cache");
      dc_req_addr = 28'h0000040;
      runRead(1'b0, 1'b1, 1'b1, 28'h0000040, 128'hA0);

      $display("[TB] instruction cache write with request stall and ready toggling");
      applyStimulus(1'b0, '0, 1'b0);
      dc_req_val  = 1'b0;
      ic_req_val  = 1'b1;
      ic_req_rw   = 1'b1;
      ic_req_addr = 28'h0000100;
      #1;
      checkOutput("wr_idle_mem_req_val", mem_req_val, 1'b0);
      for (int s = 0; s < 5; s++) begin
         applyStimulus(1'b0, '0, 1'b0);
         #1;
         checkOutput("stall_mem_req_val", mem_req_val, 1'b1);
         checkOutput("stall_addr", mem_req_addr, 28'h0000100);
         checkOutput("stall_ic_req_rdy", ic_req_rdy, 1'b0);
      end
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("wr_req_rdy", {ic_req_rdy, dc_req_rdy}, 2'b10);
      checkOutput("wr_req_rw", mem_req_rw, 1'b1);
      idx = 0;
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b0, '0, 1'b1);
         if (c == 0) begin
            ic_req_val    = 1'b0;
            ic_data_valid = 1'b1;
            ic_data_mask  = 16'hFFFF;
            dc_data_valid = 1'b1;
            dc_data_bits  = 128'hDEAD;
         end
         readyExp           = (c % 2 == 0);
         mem_req_data_ready = readyExp;
         ic_data_bits       = wbeat[idx];
         #1;
         checkOutput("wr_data_valid", mem_req_data_valid, 1'b1);
         checkOutput("wr_data_bits", mem_req_data_bits, wbeat[idx]);
         checkOutput("wr_data_mask", mem_req_data_mask, 16'hFFFF);
         checkOutput("wr_ic_data_ready", ic_data_ready, readyExp);
         checkOutput("wr_dc_data_ready", dc_data_ready, 1'b0);
         if (readyExp) idx++;
      end
      applyStimulus(1'b0, '0, 1'b1);
      mem_req_data_ready = 1'b1;
      ic_data_bits       = 128'h55;
      #1;
      checkOutput("wr_done_data_valid", mem_req_data_valid, 1'b0);
      checkOutput("wr_done_ic_data_ready", ic_data_ready, 1'b0);
      ic_data_valid = 1'b0;
      dc_data_valid = 1'b0;
      ic_req_rw     = 1'b0;

      $display("[TB] spurious response while idle");
      applyStimulus(1'b1, 128'hBAD, 1'b1);
      #1;
      checkOutput("spur_resp_val", {ic_resp_val, dc_resp_val}, 2'b00);
      checkOutput("spur_err_before", err, 1'b0);
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("spur_err_after", err, 1'b1);

      $display("[TB] repeated ties, then instruction cache alone");
      ic_req_addr = 28'h0000200;
      dc_req_addr = 28'h0000300;
      for (int k = 0; k < 3; k++) begin
         runRead(1'b1, 1'b1, tieDc[k], tieDc[k] ? 28'h0000300 : 28'h0000200,
                 128'hC0 + 128'(k * 16));
      end
      runRead(1'b1, 1'b0, 1'b0, 28'h0000200, 128'hD0);
      checkOutput("err_sticky", err, 1'b1);

      $display("[TB] reset during third read beat");
      ic_req_addr = 28'h0000500;
      applyStimulus(1'b0, '0, 1'b1);
      ic_req_val = 1'b1;
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("rr_req_addr", mem_req_addr, 28'h0000500);
      applyStimulus(1'b1, 128'hE0, 1'b1);
      #1;
      checkOutput("rr_beat0", ic_resp_val, 1'b1);
      applyStimulus(1'b1, 128'hE1, 1'b1);
      applyStimulus(1'b1, 128'hE2, 1'b1);
      reset      = 1'b0;
      ic_req_val = 1'b0;
      #1;
      checkOutput("rr_resp_val", {ic_resp_val, dc_resp_val}, 2'b00);
      checkOutput("rr_mem_req_val", mem_req_val, 1'b0);
      checkOutput("rr_req_rdy", {ic_req_rdy, dc_req_rdy}, 2'b00);
      checkOutput("rr_addr", mem_req_addr, 28'h0);
      checkOutput("rr_err_cleared", err, 1'b0);
      applyStimulus(1'b1, 128'hE3, 1'b1);
      reset = 1'b1;
      #1;
      checkOutput("rr_leftover_resp_val", {ic_resp_val, dc_resp_val}, 2'b00);
      runRead(1'b1, 1'b0, 1'b0, 28'h0000500, 128'hF0);
      checkOutput("rr_leftover_err", err, 1'b1);
      applyStimulus(1'b0, '0, 1'b1);
      ic_req_val = 1'b0;
      #1;
      checkOutput("final_idle", mem_req_val, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
